exp_align_stage: RTL and testbench



---
 rtl/gemm_align_pkg.sv | 13 +
 rtl/exp_max2.sv | 19 +
 rtl/exp_align_stage.sv | 178 +++++++++++++++++
 tb/tb_exp_align_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_align_pkg.sv
// Shared lane geometry for the GEMM significand path: lane count, field widths and the
// all-ones offset used to mark zero lanes for the downstream shifter.
package gemm_align_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned EXP_W     = 3;
  localparam int unsigned SIG_W     = 3;
  localparam int unsigned EXP_BUS_W = LANES * EXP_W;
  localparam int unsigned SIG_BUS_W = LANES * SIG_W;

  localparam logic [EXP_W-1:0] ZERO_OFFSET = '1;

endpackage

// File: rtl/exp_max2.sv
// Two-input unsigned maximum; a lane flagged zero contributes exponent 0.
module exp_max2 #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_a_zero,
  input  logic         i_b_zero,
  output logic [W-1:0] o_max
);

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;

  assign w_a   = i_a_zero ? '0 : i_a;
  assign w_b   = i_b_zero ? '0 : i_b;
  assign o_max = (w_a > w_b) ? w_a : w_b;

endmodule

// File: rtl/exp_align_stage.sv
// Two-stage exponent-alignment front end: max exponent over non-zero lanes and per-lane shifts.
// Optional stall counter output enabled by EXP_ALIGN_STALL_CNT_EN.
module exp_align_stage
  import gemm_align_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = EXP_W,
  parameter int unsigned SIG_WIDTH = SIG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES-1:0]           in_sign,
  input  logic [LANES*EXP_WIDTH-1:0] in_exp,
  input  logic [LANES*SIG_WIDTH-1:0] in_sig,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*EXP_WIDTH-1:0] exp_offset_num,
  output logic [LANES*SIG_WIDTH-1:0] significand,
  output logic [LANES-1:0]           sign,
  output logic [LANES-1:0]           zero_mask,
  output logic [EXP_WIDTH-1:0]       max_exp
`ifdef EXP_ALIGN_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cycles
`endif
);

  logic                       w_s2_adv;
  logic                       w_s1_adv;
  logic                       w_s1_load;
  logic                       w_s2_load;
  logic [LANES-1:0]           w_in_zero;
  logic [EXP_WIDTH-1:0]       w_m01;
  logic [EXP_WIDTH-1:0]       w_m23;
  logic [EXP_WIDTH-1:0]       w_max;
  logic [LANES*EXP_WIDTH-1:0] w_offset;
  logic [LANES*SIG_WIDTH-1:0] w_sig;
  logic [LANES-1:0]           w_sign;

  logic                       r_s1_valid;
  logic [LANES-1:0]           r_s1_sign;
  logic [LANES-1:0]           r_s1_zero;
  logic [LANES*EXP_WIDTH-1:0] r_s1_exp;
  logic [LANES*SIG_WIDTH-1:0] r_s1_sig;
  logic [EXP_WIDTH-1:0]       r_s1_m01;
  logic [EXP_WIDTH-1:0]       r_s1_m23;

  logic                       r_s2_valid;
  logic [LANES*EXP_WIDTH-1:0] r_s2_offset;
  logic [LANES*SIG_WIDTH-1:0] r_s2_sig;
  logic [LANES-1:0]           r_s2_sign;
  logic [LANES-1:0]           r_s2_zero;
  logic [EXP_WIDTH-1:0]       r_s2_max;

  // No skid buffer: in_ready depends combinationally on out_ready.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_s1_load = in_valid && w_s1_adv;
  assign w_s2_load = r_s1_valid && w_s2_adv;
  assign in_ready  = w_s1_adv;

  always_comb begin
    w_in_zero = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_in_zero[i] = (in_exp[i*EXP_WIDTH +: EXP_WIDTH] == '0) &&
                     (in_sig[i*SIG_WIDTH +: SIG_WIDTH] == '0);
    end
  end

  exp_max2 #(.W(EXP_WIDTH)) u_max01 (
    .i_a      (in_exp[0 +: EXP_WIDTH]),
    .i_b      (in_exp[EXP_WIDTH +: EXP_WIDTH]),
    .i_a_zero (w_in_zero[0]),
    .i_b_zero (w_in_zero[1]),
    .o_max    (w_m01)
  );

  exp_max2 #(.W(EXP_WIDTH)) u_max23 (
    .i_a      (in_exp[2*EXP_WIDTH +: EXP_WIDTH]),
    .i_b      (in_exp[3*EXP_WIDTH +: EXP_WIDTH]),
    .i_a_zero (w_in_zero[2]),
    .i_b_zero (w_in_zero[3]),
    .o_max    (w_m23)
  );

  // Pair maxima are already zero-masked in S1.
  exp_max2 #(.W(EXP_WIDTH)) u_max_s2 (
    .i_a      (r_s1_m01),
    .i_b      (r_s1_m23),
    .i_a_zero (1'b0),
    .i_b_zero (1'b0),
    .o_max    (w_max)
  );

  always_comb begin
    w_offset = '0;
    w_sig    = '0;
    w_sign   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (r_s1_zero[i]) begin
        w_offset[i*EXP_WIDTH +: EXP_WIDTH] = {EXP_WIDTH{1'b1}};
      end else begin
        w_offset[i*EXP_WIDTH +: EXP_WIDTH] = w_max - r_s1_exp[i*EXP_WIDTH +: EXP_WIDTH];
        w_sig[i*SIG_WIDTH +: SIG_WIDTH]    = r_s1_sig[i*SIG_WIDTH +: SIG_WIDTH];
        w_sign[i]                          = r_s1_sign[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= '0;
      r_s1_zero  <= '0;
      r_s1_exp   <= '0;
      r_s1_sig   <= '0;
      r_s1_m01   <= '0;
      r_s1_m23   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_load) begin
        r_s1_sign <= in_sign;
        r_s1_zero <= w_in_zero;
        r_s1_exp  <= in_exp;
        r_s1_sig  <= in_sig;
        r_s1_m01  <= w_m01;
        r_s1_m23  <= w_m23;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_offset <= '0;
      r_s2_sig    <= '0;
      r_s2_sign   <= '0;
      r_s2_zero   <= '0;
      r_s2_max    <= '0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_load) begin
        r_s2_offset <= w_offset;
        r_s2_sig    <= w_sig;
        r_s2_sign   <= w_sign;
        r_s2_zero   <= r_s1_zero;
        r_s2_max    <= w_max;
      end
    end
  end

  assign out_valid      = r_s2_valid;
  assign exp_offset_num = r_s2_offset;
  assign significand    = r_s2_sig;
  assign sign           = r_s2_sign;
  assign zero_mask      = r_s2_zero;
  assign max_exp        = r_s2_max;

`ifdef EXP_ALIGN_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_s2_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_exp_align_stage.sv
// Self-checking bench for exp_align_stage: queue-based reference model plus directed literals.
module tb_exp_align_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_sign = '0;
  logic [11:0] in_exp = '0;
  logic [11:0] in_sig = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] exp_offset_num;
  logic [11:0] significand;
  logic [3:0]  sign;
  logic [3:0]  zero_mask;
  logic [2:0]  max_exp;
`ifdef EXP_ALIGN_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  exp_align_stage #(.EXP_WIDTH(3), .SIG_WIDTH(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_sig         (in_sig),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .exp_offset_num (exp_offset_num),
    .significand    (significand),
    .sign           (sign),
    .zero_mask      (zero_mask),
    .max_exp        (max_exp)
`ifdef EXP_ALIGN_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sign;
    logic [11:0] off;
    logic [11:0] sig;
    logic [3:0]  zm;
    logic [2:0]  mx;
    int          acc_edge;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  int   n_acc = 0;
  int   n_emit = 0;
  int   n_drop = 0;
  bit   saw_block = 1'b0;

  function automatic logic [11:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // Reference: plain arithmetic over the lanes, independent of any pipeline structure.
  function automatic exp_t model(input logic [3:0] s, input logic [11:0] e, input logic [11:0] g);
    exp_t r;
    int   mx;
    int   ei;
    int   gi;
    r.sign = '0; r.off = '0; r.sig = '0; r.zm = '0; r.mx = '0; r.acc_edge = 0;
    mx = 0;
    for (int i = 0; i < 4; i++) begin
      ei = int'(e[3*i +: 3]);
      gi = int'(g[3*i +: 3]);
      if (!(ei == 0 && gi == 0) && ei > mx) mx = ei;
    end
    r.mx = 3'(mx);
    for (int i = 0; i < 4; i++) begin
      ei = int'(e[3*i +: 3]);
      gi = int'(g[3*i +: 3]);
      if (ei == 0 && gi == 0) begin
        r.zm[i] = 1'b1;
        r.off[3*i +: 3] = 3'd7;
      end else begin
        r.off[3*i +: 3] = 3'(mx - ei);
        r.sig[3*i +: 3] = 3'(gi);
        r.sign[i] = s[i];
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Beat bookkeeping at the active edge (values sampled before the DUT updates).
  always @(posedge clk or negedge rst_n) begin
    exp_t t;
    if (!rst_n) begin
      n_drop += q.size();
      q.delete();
    end else begin
      edge_cnt++;
      if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        n_emit++;
      end
      if (in_valid && in_ready) begin
        t = model(in_sign, in_exp, in_sig);
        t.acc_edge = edge_cnt;
        q.push_back(t);
        n_acc++;
      end
    end
  end

  // Every-cycle compare on the falling edge.
  always @(negedge clk) begin
    logic exp_ov;
    if (rst_n) begin
      exp_ov = (q.size() >= 2) || (q.size() == 1 && (edge_cnt - q[0].acc_edge) >= 1);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (exp_ov) begin
        chk("max_exp", max_exp, q[0].mx);
        chk("exp_offset_num", exp_offset_num, q[0].off);
        chk("significand", significand, q[0].sig);
        chk("sign", sign, q[0].sign);
        chk("zero_mask", zero_mask, q[0].zm);
      end
    end
  end

  // Call only at posedge+1; returns at accepting edge +1 with in_valid still high.
  task automatic send(input logic [3:0] s, input logic [11:0] e, input logic [11:0] g);
    bit ok;
    ok = 1'b0;
    in_sign = s; in_exp = e; in_sig = g; in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got in_ready=0 required in_ready=1 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [2:0] mx, input logic [11:0] off,
                           input logic [11:0] sg, input logic [3:0] sn, input logic [3:0] zm);
    chk({name, "_ov"}, out_valid, 1'b1);
    chk({name, "_max"}, max_exp, mx);
    chk({name, "_off"}, exp_offset_num, off);
    chk({name, "_sig"}, significand, sg);
    chk({name, "_sign"}, sign, sn);
    chk({name, "_zm"}, zero_mask, zm);
  endtask

  logic [3:0] pat = 4'b1001;

  initial begin
    #3;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_ir", in_ready, 1'b1);
    chk("rst_outs", {exp_offset_num, significand, sign, zero_mask, max_exp}, '0);
    #14 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mixed exponents, with latency pinned
    send(4'b1010, pack4(5, 2, 7, 3), pack4(1, 2, 3, 4));
    in_valid = 1'b0;
    chk("lat_t1_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check_out("t1", 3'd7, 12'h82A, 12'h8D1, 4'b1010, 4'b0000);

    // Lane 2 zero
    send(4'b0100, pack4(4, 4, 0, 1), pack4(3, 5, 0, 2));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("t2", 3'd4, 12'h7C0, 12'h42B, 4'b0000, 4'b0100);

    // All lanes zero
    send(4'hF, 12'h000, 12'h000);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("t3", 3'd0, 12'hFFF, 12'h000, 4'b0000, 4'hF);

    // Equal exponents; lane 1 has exp but zero significand (not a zero lane)
    send(4'b0011, pack4(6, 6, 6, 6), pack4(1, 0, 7, 2));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("t4", 3'd6, 12'h000, pack4(1, 0, 7, 2), 4'b0011, 4'b0000);

    // Subnormal lane 0 (exp 0, sig non-zero)
    send(4'b0001, pack4(0, 3, 3, 3), pack4(5, 1, 1, 1));
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("t5", 3'd3, 12'h003, pack4(5, 1, 1, 1), 4'b0001, 4'b0000);

    // Back-to-back stream with out_ready toggling 1,0,0,1
    fork
      begin
        logic [11:0] e;
        logic [11:0] g;
        for (int i = 0; i < 8; i++) begin
          e = 12'($urandom);
          g = 12'($urandom);
          if (i % 3 == 0) begin
            e[3*(i%4) +: 3] = 3'd0;
            g[3*(i%4) +: 3] = 3'd0;
          end
          send(4'($urandom), e, g);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = pat[c % 4];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(posedge clk); #1;
    end
    chk("stream_drained", q.size(), 0);
    chk("in_ready_drop_seen", saw_block, 1'b1);

    // Reset with two beats in flight
    send(4'b1111, pack4(1, 2, 3, 4), pack4(1, 1, 1, 1));
    send(4'b0000, pack4(7, 7, 7, 7), pack4(2, 2, 2, 2));
    in_valid = 1'b0;
    chk("pre_rst_ov", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", out_valid, 1'b0);
    chk("mid_rst_outs", {exp_offset_num, significand, sign, zero_mask, max_exp}, '0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ov", out_valid, 1'b0);
    send(4'b1010, pack4(5, 2, 7, 3), pack4(1, 2, 3, 4));
    in_valid = 1'b0;
    chk("post_rst_lat_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check_out("post_rst", 3'd7, 12'h82A, 12'h8D1, 4'b1010, 4'b0000);

`ifdef EXP_ALIGN_STALL_CNT_EN
    begin
      logic [15:0] base;
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(4'b0000, pack4(2, 2, 2, 2), pack4(1, 1, 1, 1));
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("stall_ov", out_valid, 1'b1);
      base = stall_cycles;
      repeat (10) @(posedge clk);
      #1;
      chk("stall_cycles", stall_cycles - base, 16'd10);
      out_ready = 1'b1;
    end
`endif

    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("final_empty", q.size(), 0);
    chk("beats_conserved", n_acc, n_emit + n_drop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
